// File: rtl/wb_writeback_pkg.sv
// Shared constants and types for the integer register-file writeback slice.
//   ZERO_WORD             : all-zero data word
//   F3_LB/LH/LW/LBU/LHU   : load funct3 encodings understood by load_ext
//   wb_req_t              : one arbitrated writeback request (destination + data)
package wb_writeback_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_writeback_load_ext.sv
// load_ext: combinational load-data extender.
// Ports:
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU, other codes pass the word)
//   addr_lo in  2   byte offset of the load address
//   data    in  32  raw aligned memory word
//   ext     out 32  sign/zero-extended result
module load_ext
  import wb_writeback_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] ext
);

  function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{(XLEN-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{(XLEN-16){sgn & h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[{addr_lo, 3'b000} +: 8];
    // Halfword lanes are selected by the upper offset bit only.
    half_sel = data[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   ext = ext_byte(byte_sel, 1'b1);
      F3_LH:   ext = ext_half(half_sel, 1'b1);
      F3_LBU:  ext = ext_byte(byte_sel, 1'b0);
      F3_LHU:  ext = ext_half(half_sel, 1'b0);
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/wb_writeback.sv
// wb_writeback: writer side of the integer register file.
// Arbitrates ALU and LSU results (LSU has priority), extends load data,
// registers the regfile write port and tracks pending loads for RAW hazards.
// Optional feature macro: WB_BYPASS_EN (adds fwd_a/fwd_b forwarding outputs
// and masks hazards for a same-cycle LSU accept to the source register).
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   alu_valid/ready/rd/data        ALU result handshake
//   lsu_valid/ready/rd/funct3/
//   lsu_addr_lo/lsu_data           load data handshake
//   issue_valid/issue_rd/issue_ready  load issue into the scoreboard
//   rs1, rs2, hazard_a, hazard_b   decode hazard query
//   w_en, rd, rd_data              registered regfile write port
//   fwd_a_en/data, fwd_b_en/data   forwarding (WB_BYPASS_EN only)
module wb_writeback
  import wb_writeback_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_addr_lo,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard_a,
  output logic            hazard_b,
  output logic            w_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_data
`ifdef WB_BYPASS_EN
  ,
  output logic            fwd_a_en,
  output logic            fwd_b_en,
  output logic [XLEN-1:0] fwd_a_data,
  output logic [XLEN-1:0] fwd_b_data
`endif
);

  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_OUTSTANDING);

  logic            lsu_acc_p0;
  logic            alu_acc_p0;
  logic            issue_acc_p0;
  logic [XLEN-1:0] lsu_ext_p0;
  wb_req_t         req_p0;
  logic [31:0]     pend;
  logic [31:0]     pend_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  load_ext u_load_ext (
    .funct3  (lsu_funct3),
    .addr_lo (lsu_addr_lo),
    .data    (lsu_data),
    .ext     (lsu_ext_p0)
  );

  // Stage p0: arbitration, LSU always wins
  assign lsu_ready    = 1'b1;
  assign alu_ready    = ~lsu_valid;
  assign lsu_acc_p0   = lsu_valid;
  assign alu_acc_p0   = alu_valid & ~lsu_valid;
  assign issue_ready  = ({1'b0, cnt} < MAX_C);
  assign issue_acc_p0 = issue_valid & issue_ready;

  always_comb begin
    req_p0 = '{rd: alu_rd, data: alu_data};
    if (lsu_acc_p0) req_p0 = '{rd: lsu_rd, data: lsu_ext_p0};
  end

  // Stage p1: registered regfile write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en    <= 1'b0;
      rd      <= 5'd0;
      rd_data <= ZERO_WORD;
    end else begin
      // x0 writes are accepted but never enabled.
      w_en <= (lsu_acc_p0 | alu_acc_p0) & (req_p0.rd != 5'd0);
      if (lsu_acc_p0 | alu_acc_p0) begin
        rd      <= req_p0.rd;
        rd_data <= req_p0.data;
      end
    end
  end

  // Pending-load scoreboard: the set is applied after the clear so it wins.
  always_comb begin
    pend_nxt = pend;
    if (lsu_acc_p0)   pend_nxt[lsu_rd]   = 1'b0;
    if (issue_acc_p0) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = cnt;
    case ({issue_acc_p0, lsu_acc_p0})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      // A return with nothing outstanding is a protocol error; do not wrap.
      2'b01:   cnt_nxt = (cnt == '0) ? '0 : cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

`ifdef WB_BYPASS_EN
  // The returning load reaches decode through the forwarding path next cycle.
  assign hazard_a = pend[rs1] & ~(lsu_acc_p0 & (lsu_rd == rs1));
  assign hazard_b = pend[rs2] & ~(lsu_acc_p0 & (lsu_rd == rs2));

  assign fwd_a_en   = w_en & (rd == rs1) & (rs1 != 5'd0);
  assign fwd_b_en   = w_en & (rd == rs2) & (rs2 != 5'd0);
  assign fwd_a_data = rd_data;
  assign fwd_b_data = rd_data;
`else
  assign hazard_a = pend[rs1];
  assign hazard_b = pend[rs2];
`endif

endmodule

// File: tb/tb_wb_writeback.sv
module tb_wb_writeback;
  import wb_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic [31:0] lsu_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        hazard_a, hazard_b, w_en;
  logic [4:0]  rd;
  logic [31:0] rd_data;
`ifdef WB_BYPASS_EN
  logic        fwd_a_en, fwd_b_en;
  logic [31:0] fwd_a_data, fwd_b_data;
`endif

  always #5 clk = ~clk;

  wb_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_funct3(lsu_funct3),
    .lsu_addr_lo(lsu_addr_lo), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .w_en(w_en), .rd(rd), .rd_data(rd_data)
`ifdef WB_BYPASS_EN
    , .fwd_a_en(fwd_a_en), .fwd_b_en(fwd_b_en), .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
`endif
  );

  typedef struct {
    logic        w_en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] lsu_d;
    wr_t         exp;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_addr_lo = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  // Advance one clock and compare the write port against the oldest expectation.
  task automatic cycle_check(input string tag);
    wr_t e;
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".w_en"}, {31'd0, w_en}, {31'd0, e.w_en});
      if (e.w_en) begin
        chk({tag, ".rd"}, {27'd0, rd}, {27'd0, e.rd});
        chk({tag, ".rd_data"}, rd_data, e.data);
      end
    end
  endtask

  task automatic push(input logic en, input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.w_en = en; e.rd = r; e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 0; rs1 = 3; rs2 = 4;
    idle_inputs();
    tbl[0]  = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0, '{1'b1, 5'd5,  32'h0000_1234}};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  3'b000, 2'd0, 32'h0, '{1'b0, 5'd0,  32'h0}};
    tbl[2]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd10, 3'b000, 2'd3, 32'h80FF_7F01, '{1'b1, 5'd10, 32'hFFFF_FF80}};
    tbl[3]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd11, 3'b100, 2'd0, 32'h80FF_7F01, '{1'b1, 5'd11, 32'h0000_0001}};
    tbl[4]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd12, 3'b001, 2'd2, 32'h80FF_7F01, '{1'b1, 5'd12, 32'hFFFF_80FF}};
    tbl[5]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd13, 3'b101, 2'd2, 32'h80FF_7F01, '{1'b1, 5'd13, 32'h0000_80FF}};
    tbl[6]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd14, 3'b010, 2'd0, 32'h80FF_7F01, '{1'b1, 5'd14, 32'h80FF_7F01}};
    tbl[7]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd15, 3'b000, 2'd1, 32'h80FF_7F01, '{1'b1, 5'd15, 32'h0000_007F}};
    tbl[8]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd16, 3'b001, 2'd0, 32'h80FF_7F01, '{1'b1, 5'd16, 32'h0000_7F01}};
    tbl[9]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd17, 3'b011, 2'd1, 32'h80FF_7F01, '{1'b1, 5'd17, 32'h80FF_7F01}};
    tbl[10] = '{1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0, '{1'b0, 5'd0, 32'h0}};
    tbl[11] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd18, 3'b100, 2'd2, 32'h80FF_7F01, '{1'b1, 5'd18, 32'h0000_00FF}};
    tbl[12] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd19, 3'b000, 2'd2, 32'h80FF_7F01, '{1'b1, 5'd19, 32'hFFFF_FFFF}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.w_en", {31'd0, w_en}, 32'd0);
    chk("rst.rd", {27'd0, rd}, 32'd0);
    chk("rst.rd_data", rd_data, 32'd0);
    chk("rst.issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst.hazard_a", {31'd0, hazard_a}, 32'd0);
    rst_n = 1;

    // Table-driven writeback vectors
    for (int i = 0; i < 13; i++) begin
      alu_valid = tbl[i].alu_v; alu_rd = tbl[i].alu_rd; alu_data = tbl[i].alu_d;
      lsu_valid = tbl[i].lsu_v; lsu_rd = tbl[i].lsu_rd; lsu_funct3 = tbl[i].f3;
      lsu_addr_lo = tbl[i].lo; lsu_data = tbl[i].lsu_d;
      #1;
      chk($sformatf("vec%0d.alu_ready", i), {31'd0, alu_ready}, {31'd0, ~tbl[i].lsu_v});
      push(tbl[i].exp.w_en, tbl[i].exp.rd, tbl[i].exp.data);
      cycle_check($sformatf("vec%0d", i));
    end
    idle_inputs();

    // ALU and LSU together: LSU first, ALU next cycle
    alu_valid = 1; alu_rd = 6; alu_data = 32'hCAFE_0006;
    lsu_valid = 1; lsu_rd = 9; lsu_funct3 = F3_LW; lsu_data = 32'h1111_2222;
    #1;
    chk("conflict.alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("conflict.lsu_ready", {31'd0, lsu_ready}, 32'd1);
    push(1'b1, 5'd9, 32'h1111_2222);
    cycle_check("conflict.lsu");
    lsu_valid = 0;
    #1;
    chk("conflict.alu_ready2", {31'd0, alu_ready}, 32'd1);
    push(1'b1, 5'd6, 32'hCAFE_0006);
    cycle_check("conflict.alu");
    idle_inputs();
    push(1'b0, 5'd0, 32'h0);
    cycle_check("idle");

    // Scoreboard: issue x3, x4
    rs1 = 3; rs2 = 4;
    issue_valid = 1; issue_rd = 3;
    push(1'b0, 5'd0, 32'h0);
    cycle_check("issue3");
    issue_rd = 4;
    #1;
    chk("issue4.ready", {31'd0, issue_ready}, 32'd1);
    push(1'b0, 5'd0, 32'h0);
    cycle_check("issue4");
    issue_valid = 0;
    #1;
    chk("full.issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("full.hazard_a", {31'd0, hazard_a}, 32'd1);
    chk("full.hazard_b", {31'd0, hazard_b}, 32'd1);
    // x4 returns
    lsu_valid = 1; lsu_rd = 4; lsu_funct3 = F3_LW; lsu_data = 32'h0000_0044;
    push(1'b1, 5'd4, 32'h0000_0044);
    cycle_check("ret4");
    lsu_valid = 0;
    #1;
    chk("ret4.hazard_b", {31'd0, hazard_b}, 32'd0);
    chk("ret4.issue_ready", {31'd0, issue_ready}, 32'd1);
    // x3 returns while x3 is issued again: set wins, count unchanged
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h0000_0033;
    issue_valid = 1; issue_rd = 3;
    #1;
`ifdef WB_BYPASS_EN
    chk("both.hazard_a", {31'd0, hazard_a}, 32'd0);
`else
    chk("both.hazard_a", {31'd0, hazard_a}, 32'd1);
`endif
    push(1'b1, 5'd3, 32'h0000_0033);
    cycle_check("both");
    lsu_valid = 0; issue_valid = 0;
    #1;
    chk("both.pend3", {31'd0, hazard_a}, 32'd1);
    chk("both.issue_ready", {31'd0, issue_ready}, 32'd1);
    issue_valid = 1; issue_rd = 5;
    push(1'b0, 5'd0, 32'h0);
    cycle_check("issue5");
    issue_valid = 0; rs2 = 5;
    #1;
    chk("cnt2.issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("cnt2.hazard_b", {31'd0, hazard_b}, 32'd1);

    // Reset mid-stream drops pending state and the in-flight write
    rst_n = 0; alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    push(1'b0, 5'd0, 32'h0);
    cycle_check("midrst");
    chk("midrst.hazard_a", {31'd0, hazard_a}, 32'd0);
    chk("midrst.hazard_b", {31'd0, hazard_b}, 32'd0);
    chk("midrst.issue_ready", {31'd0, issue_ready}, 32'd1);
    rst_n = 1; idle_inputs();

    // Load return with nothing outstanding must not wrap the counter
    lsu_valid = 1; lsu_rd = 8; lsu_funct3 = F3_LW; lsu_data = 32'h0000_0088;
    push(1'b1, 5'd8, 32'h0000_0088);
    cycle_check("underflow");
    lsu_valid = 0; issue_valid = 1; issue_rd = 1;
    #1;
    chk("underflow.issue_ready", {31'd0, issue_ready}, 32'd1);
    push(1'b0, 5'd0, 32'h0);
    cycle_check("uf.issue1");
    issue_rd = 2;
    push(1'b0, 5'd0, 32'h0);
    cycle_check("uf.issue2");
    issue_valid = 0;
    #1;
    chk("uf.full", {31'd0, issue_ready}, 32'd0);

`ifdef WB_BYPASS_EN
    idle_inputs();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_00A5;
    push(1'b1, 5'd7, 32'h0000_00A5);
    cycle_check("fwd.write");
    alu_valid = 0; rs1 = 7; rs2 = 7;
    #1;
    chk("fwd_a_en", {31'd0, fwd_a_en}, 32'd1);
    chk("fwd_a_data", fwd_a_data, 32'h0000_00A5);
    chk("fwd_b_en", {31'd0, fwd_b_en}, 32'd1);
    rs1 = 0;
    #1;
    chk("fwd_a_en.x0", {31'd0, fwd_a_en}, 32'd0);
`endif

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
